vend_engine: RTL

VEND_ENGINE -- requirements
Module: vend_engine

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_if.sv | 31 +++
 rtl/vend_inventory.sv | 50 +++++
 rtl/vend_engine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings for the vending engine: request opcodes, response error
// codes and the request-sequencing FSM states.
package vend_pkg;

  typedef enum logic [1:0] {
    OP_BUY       = 2'd0,
    OP_WITHDRAW  = 2'd1,
    OP_RESTOCK   = 2'd2,
    OP_SET_PRICE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_STOCK = 2'd1,
    ERR_FUNDS = 2'd2,
    ERR_OVF   = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/vend_if.sv
// Request/response bundle between a requester (master) and the vending engine (slave).
interface vend_if #(
  parameter int N_PROD = 8,
  parameter int QTY_W  = 4,
  parameter int BANK_W = 11
);
  localparam int SEL_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [SEL_W-1:0]  prod_sel;
  logic [QTY_W-1:0]  qty;
  logic [BANK_W-1:0] amount;
  logic              rsp_valid;
  logic [1:0]        rsp_err;
  logic [BANK_W-1:0] change_out;
  logic [BANK_W-1:0] bank;
  logic [QTY_W-1:0]  stock_out;
  logic              redlight;

  modport master (
    output op_valid, op_code, prod_sel, qty, amount,
    input  op_ready, rsp_valid, rsp_err, change_out, bank, stock_out, redlight
  );

  modport slave (
    input  op_valid, op_code, prod_sel, qty, amount,
    output op_ready, rsp_valid, rsp_err, change_out, bank, stock_out, redlight
  );
endinterface

// File: rtl/vend_inventory.sv
// Per-slot stock and price storage: one combinational read port, one
// write port that updates both fields of a slot in the same cycle.
module vend_inventory #(
  parameter int N_PROD    = 8,
  parameter int PRICE_W   = 4,
  parameter int QTY_W     = 4,
  parameter int DEF_PRICE = 1,
  localparam int SEL_W    = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [QTY_W-1:0]   rd_stock,
  output logic [PRICE_W-1:0] rd_price,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_sel,
  input  logic [QTY_W-1:0]   wr_stock,
  input  logic [PRICE_W-1:0] wr_price
);
  logic [QTY_W-1:0]   stock_q [N_PROD];
  logic [QTY_W-1:0]   stock_d [N_PROD];
  logic [PRICE_W-1:0] price_q [N_PROD];
  logic [PRICE_W-1:0] price_d [N_PROD];

  always_comb begin
    stock_d = stock_q;
    price_d = price_q;
    if (wr_en && (int'(wr_sel) < N_PROD)) begin
      stock_d[wr_sel] = wr_stock;
      price_d[wr_sel] = wr_price;
    end
  end

  // NOTE: the arrays are small register files, not RAM macros, so they are
  // reset explicitly: every slot must come up empty at the default price.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PROD; i++) begin
        stock_q[i] <= '0;
        price_q[i] <= PRICE_W'(DEF_PRICE);
      end
    end else begin
      stock_q <= stock_d;
      price_q <= price_d;
    end
  end

  assign rd_stock = (int'(rd_sel) < N_PROD) ? stock_q[rd_sel] : '0;
  assign rd_price = (int'(rd_sel) < N_PROD) ? price_q[rd_sel] : '0;
endmodule

// File: rtl/vend_engine.sv
// Vending engine: accepts one request every three cycles (IDLE/EXEC/RESP),
// evaluates it in EXEC and commits inventory/bank changes on the EXEC->RESP edge.
module vend_engine
  import vend_pkg::*;
#(
  parameter int N_PROD    = 8,
  parameter int PRICE_W   = 4,
  parameter int QTY_W     = 4,
  parameter int BANK_W    = 11,
  parameter int DEF_PRICE = 1
) (
  input  logic   clk,
  input  logic   rst,
  vend_if.slave  vif
);
  localparam int SEL_W  = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int COST_W = PRICE_W + QTY_W;
  localparam int WIDE_W = BANK_W + COST_W + 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [BANK_W-1:0]  amount_q, amount_d;
  logic [QTY_W-1:0]   cap_stock_q, cap_stock_d;
  logic [PRICE_W-1:0] cap_price_q, cap_price_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [BANK_W-1:0]  change_q, change_d;
  err_e               err_q, err_d;
  logic               redlight_q, redlight_d;

  logic [QTY_W-1:0]   rd_stock;
  logic [PRICE_W-1:0] rd_price;
  logic               wr_en;

  // Result of the captured request, evaluated every cycle and used only in EXEC.
  err_e               ex_err;
  logic [BANK_W-1:0]  ex_change, ex_bank;
  logic [QTY_W-1:0]   ex_stock;
  logic [PRICE_W-1:0] ex_price;
  logic [WIDE_W-1:0]  cost_w, amount_w, bank_w, bank_sum, change_w;
  logic [QTY_W:0]     stock_sum;

  vend_inventory #(
    .N_PROD(N_PROD), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEF_PRICE(DEF_PRICE)
  ) u_inv (
    .clk, .rst,
    .rd_sel(vif.prod_sel), .rd_stock, .rd_price,
    .wr_en, .wr_sel(sel_q), .wr_stock(ex_stock), .wr_price(ex_price)
  );

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    cost_w    = WIDE_W'(cap_price_q) * WIDE_W'(qty_q);
    amount_w  = WIDE_W'(amount_q);
    bank_w    = WIDE_W'(bank_q);
    bank_sum  = bank_w + cost_w;
    change_w  = amount_w - cost_w;
    stock_sum = {1'b0, cap_stock_q} + {1'b0, qty_q};
    ex_err    = ERR_OK;
    ex_change = '0;
    ex_bank   = bank_q;
    ex_stock  = cap_stock_q;
    ex_price  = cap_price_q;
    unique case (op_q)
      OP_BUY: begin
        if (qty_q == '0 || cap_stock_q < qty_q)         ex_err = ERR_STOCK;
        else if (amount_w < cost_w)                      ex_err = ERR_FUNDS;
        else if (bank_sum > WIDE_W'({BANK_W{1'b1}}))     ex_err = ERR_OVF;
        if (ex_err == ERR_OK) begin
          ex_stock  = cap_stock_q - qty_q;
          ex_bank   = bank_sum[BANK_W-1:0];
          ex_change = change_w[BANK_W-1:0];
        end else begin
          ex_change = amount_q;
        end
      end
      OP_WITHDRAW: begin
        if (amount_q > bank_q) begin
          ex_err = ERR_FUNDS;
        end else begin
          ex_change = (amount_q == '0) ? bank_q : amount_q;
          ex_bank   = bank_q - ex_change;
        end
      end
      OP_RESTOCK: begin
        if (stock_sum[QTY_W]) ex_err   = ERR_OVF;
        else                  ex_stock = stock_sum[QTY_W-1:0];
      end
      OP_SET_PRICE: ex_price = amount_q[PRICE_W-1:0];
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sel_d       = sel_q;
    qty_d       = qty_q;
    amount_d    = amount_q;
    cap_stock_d = cap_stock_q;
    cap_price_d = cap_price_q;
    bank_d      = bank_q;
    change_d    = change_q;
    err_d       = err_q;
    redlight_d  = redlight_q;
    wr_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: if (vif.op_valid) begin
        // Nothing is written before EXEC->RESP, so the slot read now is exact.
        op_d        = op_e'(vif.op_code);
        sel_d       = vif.prod_sel;
        qty_d       = vif.qty;
        amount_d    = vif.amount;
        cap_stock_d = rd_stock;
        cap_price_d = rd_price;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        wr_en      = (ex_err == ERR_OK);
        bank_d     = ex_bank;
        change_d   = ex_change;
        err_d      = ex_err;
        redlight_d = (ex_err != ERR_OK);
        state_d    = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_BUY;
      sel_q       <= '0;
      qty_q       <= '0;
      amount_q    <= '0;
      cap_stock_q <= '0;
      cap_price_q <= '0;
      bank_q      <= '0;
      change_q    <= '0;
      err_q       <= ERR_OK;
      redlight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      qty_q       <= qty_d;
      amount_q    <= amount_d;
      cap_stock_q <= cap_stock_d;
      cap_price_q <= cap_price_d;
      bank_q      <= bank_d;
      change_q    <= change_d;
      err_q       <= err_d;
      redlight_q  <= redlight_d;
    end
  end

  assign vif.op_ready   = (state_q == ST_IDLE);
  assign vif.rsp_valid  = (state_q == ST_RESP);
  assign vif.rsp_err    = err_q;
  assign vif.change_out = change_q;
  assign vif.bank       = bank_q;
  assign vif.stock_out  = rd_stock;
  assign vif.redlight   = redlight_q;
endmodule
